// File: rtl/trail_sched_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the trail write scheduler.
package trail_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } sched_state_e;

  localparam int TRAIL_ADDR_W  = 12;
  localparam int TRAIL_COLOR_W = 3;
  localparam int TRAIL_DEPTH   = 4096;

  localparam logic [TRAIL_COLOR_W-1:0] CLEAR_COLOR = '0;

endpackage

// File: rtl/rr_arbiter.sv
`timescale 1ns/1ps
// Combinational round-robin pick: search begins one past the last winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_vld_o
);

  always_comb begin
    int j;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(last_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_vld_o && req_i[j]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = IDX_W'(j);
        gnt_o[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trail_write_scheduler.sv
`timescale 1ns/1ps
// Arbitrates bike trail writes onto the single trail_mem port and runs clear sweeps.
// Optional TRAIL_SCHED_DEDUP_EN drops a grant that repeats a bike's previous address.
//   state | meaning
//   IDLE  | accept and arbitrate bike writes
//   CLEAR | write colour 0 to one cell per cycle
//   DONE  | one cycle pulsing clear_done
module trail_write_scheduler
  import trail_sched_pkg::*;
#(
  parameter int NUM_BIKES = 4,
  parameter int ADDR_W    = TRAIL_ADDR_W,
  parameter int COLOR_W   = TRAIL_COLOR_W,
  parameter int DEPTH     = TRAIL_DEPTH
) (
  input  logic                        iVGA_CLK,
  input  logic                        iRST_n,
  input  logic [NUM_BIKES-1:0]        bike_valid,
  input  logic [NUM_BIKES*ADDR_W-1:0] bike_addr,
  output logic [NUM_BIKES-1:0]        bike_ready,
  input  logic                        clear_req,
  output logic                        clear_busy,
  output logic                        clear_done,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [COLOR_W-1:0]          wr_data,
  output logic [NUM_BIKES-1:0]        gnt
);

  localparam int IDX_W = (NUM_BIKES > 1) ? $clog2(NUM_BIKES) : 1;

  sched_state_e          state_q, state_d;
  logic [NUM_BIKES-1:0]  full_q, full_d;
  logic [ADDR_W-1:0]     addr_q [NUM_BIKES];
  logic [ADDR_W-1:0]     addr_d [NUM_BIKES];
  logic [IDX_W-1:0]      last_q, last_d;
  logic [ADDR_W-1:0]     clr_addr_q, clr_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [COLOR_W-1:0]    wr_data_q, wr_data_d;
  logic [NUM_BIKES-1:0]  gnt_q, gnt_d;
  logic                  clear_busy_q, clear_busy_d;
  logic                  clear_done_q, clear_done_d;

  logic [NUM_BIKES-1:0]  arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_vld;
  logic                  dup_hit;

`ifdef TRAIL_SCHED_DEDUP_EN
  logic [ADDR_W-1:0]     last_addr_q [NUM_BIKES];
  logic [ADDR_W-1:0]     last_addr_d [NUM_BIKES];
  logic [NUM_BIKES-1:0]  last_vld_q, last_vld_d;
`endif

  rr_arbiter #(.NUM_REQ(NUM_BIKES), .IDX_W(IDX_W)) u_arb (
    .req_i     (full_q),
    .last_i    (last_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  assign bike_ready = (state_q == IDLE && !clear_req) ? ~full_q : '0;

  always_comb begin
`ifdef TRAIL_SCHED_DEDUP_EN
    dup_hit = last_vld_q[arb_idx] && (last_addr_q[arb_idx] == addr_q[arb_idx]);
`else
    dup_hit = 1'b0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    full_d       = full_q;
    addr_d       = addr_q;
    last_d       = last_q;
    clr_addr_d   = clr_addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    gnt_d        = '0;
    clear_done_d = 1'b0;
`ifdef TRAIL_SCHED_DEDUP_EN
    last_addr_d  = last_addr_q;
    last_vld_d   = last_vld_q;
`endif

    for (int i = 0; i < NUM_BIKES; i++) begin
      if (bike_valid[i] && bike_ready[i]) begin
        full_d[i] = 1'b1;
        addr_d[i] = bike_addr[i*ADDR_W +: ADDR_W];
      end
    end

    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d    = CLEAR;
          full_d     = '0;
          clr_addr_d = '0;
`ifdef TRAIL_SCHED_DEDUP_EN
          last_vld_d = '0;
`endif
        end else if (arb_vld) begin
          full_d[arb_idx] = 1'b0;
          last_d          = arb_idx;
          if (!dup_hit) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q[arb_idx];
            wr_data_d = COLOR_W'(arb_idx) + COLOR_W'(1);
            gnt_d     = arb_gnt;
`ifdef TRAIL_SCHED_DEDUP_EN
            last_addr_d[arb_idx] = addr_q[arb_idx];
            last_vld_d[arb_idx]  = 1'b1;
`endif
          end
        end
      end
      CLEAR: begin
        wr_en_d    = 1'b1;
        wr_addr_d  = clr_addr_q;
        wr_data_d  = CLEAR_COLOR;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == ADDR_W'(DEPTH - 1)) state_d = DONE;
      end
      DONE: begin
        clear_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // busy covers entry through the cycle the last clear write is presented
    clear_busy_d = (state_d == CLEAR) || (state_q == CLEAR);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q      <= IDLE;
      full_q       <= '0;
      for (int i = 0; i < NUM_BIKES; i++) addr_q[i] <= '0;
      last_q       <= IDX_W'(NUM_BIKES - 1);
      clr_addr_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      gnt_q        <= '0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      addr_q       <= addr_d;
      last_q       <= last_d;
      clr_addr_q   <= clr_addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      gnt_q        <= gnt_d;
      clear_busy_q <= clear_busy_d;
      clear_done_q <= clear_done_d;
    end
  end

`ifdef TRAIL_SCHED_DEDUP_EN
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int i = 0; i < NUM_BIKES; i++) last_addr_q[i] <= '0;
      last_vld_q <= '0;
    end else begin
      last_addr_q <= last_addr_d;
      last_vld_q  <= last_vld_d;
    end
  end
`endif

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign gnt        = gnt_q;
  assign clear_busy = clear_busy_q;
  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_trail_write_scheduler.sv
`timescale 1ns/1ps
// Directed bench for trail_write_scheduler (default build and TRAIL_SCHED_DEDUP_EN).
module tb_trail_write_scheduler;

  localparam int NB = 4;
  localparam int AW = 12;
  localparam int CW = 3;
  localparam int DEPTH = 4096;

  logic            clk;
  logic            rst_n;
  logic [NB-1:0]   bike_valid;
  logic [NB*AW-1:0] bike_addr;
  logic [NB-1:0]   bike_ready;
  logic            clear_req;
  logic            clear_busy;
  logic            clear_done;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [CW-1:0]   wr_data;
  logic [NB-1:0]   gnt;

  int n_cmp = 0;
  int n_err = 0;

  trail_write_scheduler #(.NUM_BIKES(NB), .ADDR_W(AW), .COLOR_W(CW), .DEPTH(DEPTH)) dut (
    .iVGA_CLK   (clk),
    .iRST_n     (rst_n),
    .bike_valid (bike_valid),
    .bike_addr  (bike_addr),
    .bike_ready (bike_ready),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .gnt        (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [NB-1:0] g, input logic [AW-1:0] a,
                             input logic [CW-1:0] d);
    check({tag, ".wr_en"}, 32'(wr_en), 32'd1);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".addr"}, 32'(wr_addr), 32'(a));
    check({tag, ".data"}, 32'(wr_data), 32'(d));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int bad;
    int waited;
    rst_n      = 1'b0;
    bike_valid = '0;
    bike_addr  = '0;
    clear_req  = 1'b0;
    tick();
    tick();

    // reset values
    check("rst.wr_en", 32'(wr_en), 32'd0);
    check("rst.wr_addr", 32'(wr_addr), 32'd0);
    check("rst.wr_data", 32'(wr_data), 32'd0);
    check("rst.gnt", 32'(gnt), 32'd0);
    check("rst.busy", 32'(clear_busy), 32'd0);
    check("rst.done", 32'(clear_done), 32'd0);
    check("rst.ready", 32'(bike_ready), 32'hF);
    rst_n = 1'b1;
    tick();

    // single bike 0 write, two-edge latency
    bike_valid = 4'b0001;
    bike_addr[0*AW +: AW] = 12'h123;
    #1 check("t1.ready_pre", 32'(bike_ready), 32'hF);
    tick();
    bike_valid = '0;
    check("t1.wr_en_e1", 32'(wr_en), 32'd0);
    check("t1.ready_full", 32'(bike_ready), 32'hE);
    tick();
    check_write("t1.e2", 4'b0001, 12'h123, 3'd1);
    tick();
    check("t1.idle_wr_en", 32'(wr_en), 32'd0);
    check("t1.idle_gnt", 32'(gnt), 32'd0);
    check("t1.hold_addr", 32'(wr_addr), 32'h123);
    check("t1.hold_data", 32'(wr_data), 32'd1);

    // four-way burst from a fresh last pointer, then a second burst
    do_reset();
    for (int b = 0; b < 2; b++) begin
      bike_valid = 4'b1111;
      for (int i = 0; i < NB; i++) bike_addr[i*AW +: AW] = AW'(12'h010 + i);
      tick();
      bike_valid = '0;
      check("t2.ready_all_full", 32'(bike_ready), 32'h0);
      for (int i = 0; i < NB; i++) begin
        tick();
        check_write($sformatf("t2.b%0d.g%0d", b, i), NB'(1 << i), AW'(12'h010 + i), CW'(i + 1));
      end
    end

    // rotation: last=3, bikes 1 and 3 -> 1 then 3
    bike_valid = 4'b1010;
    bike_addr[1*AW +: AW] = 12'h0A1;
    bike_addr[3*AW +: AW] = 12'h0A3;
    tick();
    bike_valid = '0;
    tick();
    check_write("t2.rot1", 4'b0010, 12'h0A1, 3'd2);
    tick();
    check_write("t2.rot3", 4'b1000, 12'h0A3, 3'd4);
    // last=3 again, bikes 0 and 3 -> 0 then 3
    bike_valid = 4'b1001;
    bike_addr[0*AW +: AW] = 12'h0B0;
    bike_addr[3*AW +: AW] = 12'h0B3;
    tick();
    bike_valid = '0;
    tick();
    check_write("t2.wrap0", 4'b0001, 12'h0B0, 3'd1);
    tick();
    check_write("t2.wrap3", 4'b1000, 12'h0B3, 3'd4);
    tick();

    // clear with bikes 1 and 2 holding entries
    bike_valid = 4'b0110;
    bike_addr[1*AW +: AW] = 12'h321;
    bike_addr[2*AW +: AW] = 12'h322;
    tick();
    bike_valid = '0;
    clear_req  = 1'b1;
    #1 check("t3.ready_clr", 32'(bike_ready), 32'h0);
    tick();
    clear_req = 1'b0;
    check("t3.busy_entry", 32'(clear_busy), 32'd1);
    check("t3.wr_en_entry", 32'(wr_en), 32'd0);
    bad = 0;
    for (int n = 0; n < DEPTH; n++) begin
      tick();
      if (wr_en !== 1'b1 || wr_addr !== AW'(n) || wr_data !== '0 || gnt !== '0 ||
          clear_busy !== 1'b1 || clear_done !== 1'b0 || bike_ready !== '0)
        bad++;
    end
    check("t3.sweep_bad_cycles", 32'(bad), 32'd0);
    check("t3.last_addr", 32'(wr_addr), 32'hFFF);
    tick();
    check("t3.done", 32'(clear_done), 32'd1);
    check("t3.done_wr_en", 32'(wr_en), 32'd0);
    check("t3.done_busy", 32'(clear_busy), 32'd0);
    tick();
    check("t3.done_pulse", 32'(clear_done), 32'd0);
    check("t3.ready_after", 32'(bike_ready), 32'hF);
    bad = 0;
    for (int n = 0; n < 4; n++) begin
      if (wr_en !== 1'b0) bad++;
      tick();
    end
    check("t3.buffers_dropped", 32'(bad), 32'd0);

    // clear_req with bike 0 valid: no accept, sweep starts
    bike_valid = 4'b0001;
    bike_addr[0*AW +: AW] = 12'h777;
    clear_req  = 1'b1;
    #1 check("t4.ready0", 32'(bike_ready), 32'h0);
    tick();
    bike_valid = '0;
    clear_req  = 1'b0;
    check("t4.busy", 32'(clear_busy), 32'd1);
    tick();
    check_write("t4.first", 4'b0000, 12'h000, 3'd0);

    // reset mid-sweep at address 0x800
    waited = 0;
    while (wr_addr !== 12'h800 && waited < 3000) begin
      tick();
      waited++;
    end
    check("t5.reach_800", 32'(wr_addr), 32'h800);
    rst_n = 1'b0;
    #1;
    check("t5.rst_wr_en", 32'(wr_en), 32'd0);
    check("t5.rst_wr_addr", 32'(wr_addr), 32'd0);
    check("t5.rst_busy", 32'(clear_busy), 32'd0);
    check("t5.rst_gnt", 32'(gnt), 32'd0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (wr_en !== 1'b0 || clear_busy !== 1'b0 || clear_done !== 1'b0) bad++;
    end
    check("t5.no_resume", 32'(bad), 32'd0);

    // bike 2 sends 0x050 twice, then 0x051
    bike_valid = 4'b0100;
    bike_addr[2*AW +: AW] = 12'h050;
    tick();
    bike_valid = '0;
    tick();
    check_write("t6.first", 4'b0100, 12'h050, 3'd3);
    bike_valid = 4'b0100;
    tick();
    bike_valid = '0;
    tick();
`ifdef TRAIL_SCHED_DEDUP_EN
    check("t6.dup_wr_en", 32'(wr_en), 32'd0);
    check("t6.dup_gnt", 32'(gnt), 32'd0);
    check("t6.dup_ready", 32'(bike_ready), 32'hF);
`else
    check_write("t6.repeat", 4'b0100, 12'h050, 3'd3);
`endif
    bike_valid = 4'b0100;
    bike_addr[2*AW +: AW] = 12'h051;
    tick();
    bike_valid = '0;
    tick();
    check_write("t6.new", 4'b0100, 12'h051, 3'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trail_write_scheduler.md
# trail_write_scheduler

Shares the single write port of the trail memory between up to four bike position sources, and sequences a full-map clear sweep. It sits between the bike-position logic and `trail_mem`. Each bike hands over one trail cell (12-bit trail address plus colour) with a valid/ready handshake. The block issues at most one write per clock, chosen round-robin. On `clear_req` it replaces the asynchronous `aclr` path by writing colour 0 to every cell in order.

## Interface
- `NUM_BIKES`, 4, number of requesters (2..4)
- `ADDR_W`, 12, trail address width
- `COLOR_W`, 3, trail colour width; bike i writes colour i+1
- `DEPTH`, 4096, cells swept by a clear (≤ 2^ADDR_W)

Ports:
- `iVGA_CLK`  in  1  sole clock, rising edge
- `iRST_n`  in  1  asynchronous, active-low reset
- `bike_valid`  in  NUM_BIKES  per-bike request valid
- `bike_addr`  in  NUM_BIKES*ADDR_W  packed trail addresses; bike i at [i*ADDR_W +: ADDR_W]
- `bike_ready`  out  NUM_BIKES  per-bike accept
- `clear_req`  in  1  start clear sweep (level, sampled in IDLE)
- `clear_busy`  out  1  high while sweeping
- `clear_done`  out  1  one-cycle pulse after the last clear write
- `wr_en`  out  1  trail_mem write enable
- `wr_addr`  out  ADDR_W  trail_mem write address
- `wr_data`  out  COLOR_W  trail_mem write data
- `gnt`  out  NUM_BIKES  one-hot; marks the bike whose write is on `wr_*` this cycle

## Operation
- Per bike: a one-entry holding buffer (`full`, `addr`).
  - `bike_ready[i] = (state==IDLE) & ~full[i] & ~clear_req`.
  - The buffer loads on any edge where `bike_valid[i] & bike_ready[i]`.
- Arbitration, IDLE only:
  - Candidates are the full buffers. Search starts at `last+1` mod NUM_BIKES. `last` resets to NUM_BIKES-1, so bike 0 wins first.
  - The winner's entry is registered onto `wr_addr`/`wr_data` with `wr_en=1` and `gnt[i]=1`. The winner's buffer clears and `last` updates on that same edge.
  - With no candidates, `wr_en=0` and `gnt=0`. `wr_addr`/`wr_data` hold their last values.
- State machine:
  - IDLE → CLEAR when `clear_req=1` at an edge. All holding buffers are discarded on that edge; `clr_addr` is set to 0.
  - CLEAR: on each edge, register `wr_en=1`, `wr_addr=clr_addr`, `wr_data=0`, `gnt=0`, then increment `clr_addr`. Moves to DONE after issuing address DEPTH-1.
  - DONE: lasts one cycle with `clear_done=1` and `wr_en=0`, then returns to IDLE.
  - `clear_req` is ignored in CLEAR and DONE. If it is still high in IDLE, a new sweep starts.
  - `clear_busy=1` in CLEAR.
- Simultaneous events:
  - `clear_req` beats all bike requests in the same cycle. Ready is low, so nothing is accepted.
  - Two bikes with the same address are written on consecutive grants. The later write wins in memory.

## Timing
- Reset values: `wr_en=0`, `wr_addr=0`, `wr_data=0`, `gnt=0`, `clear_busy=0`, `clear_done=0`. All buffers are empty, `last=NUM_BIKES-1`, state is IDLE.
- All outputs except `bike_ready` are registered. `bike_ready` is combinational from state, `full` and `clear_req`.
- Latency from handshake edge k to `wr_en` visible: wr_en is high in the cycle after edge k+1, if the bike is uncontended. Worst case is NUM_BIKES+1 edges.
- Throughput: 1 write/cycle overall, and 1 accept per 2 cycles per bike.
- Clear: DEPTH consecutive `wr_en` cycles, then `clear_done` in cycle DEPTH+1 after entry.
- Reset asserted mid-sweep or mid-grant: everything returns to reset values at once. The partial sweep is not resumed.

## Configuration
- `TRAIL_SCHED_DEDUP_EN` defined:
  - Each bike keeps `last_addr[i]` plus a valid bit. Both are cleared on reset and on clear entry.
  - A granted entry whose address equals `last_addr[i]` has its buffer cleared and `last` updated as normal, but `wr_en` stays 0 and `gnt` stays 0.
- Not defined: every granted entry produces a write.

## Structure
- Package `trail_sched_pkg`:
  - state enum (IDLE, CLEAR, DONE)
  - `TRAIL_ADDR_W=12`, `TRAIL_COLOR_W=3`, `TRAIL_DEPTH=4096`
  - clear colour constant 0
- Sub-module `rr_arbiter`:
  - inputs: NUM_BIKES-wide request vector, `last` pointer
  - outputs: one-hot grant, encoded index
  - combinational

## Test plan
- Reset, then bike 0 valid with addr 0x123. Expect accept at edge 1, then `wr_en=1`, `wr_addr=0x123`, `wr_data=1`, `gnt=0001` in the cycle after edge 2.
- All four bikes valid in the same cycle (addr 0x010..0x013). Expect grants 0,1,2,3 on consecutive cycles with data 1,2,3,4. A second burst starts from bike 0, since `last`=3.
- `clear_req` pulse with bikes 1 and 2 holding full buffers. Expect buffers dropped, 4096 writes of data 0 over addr 0..4095, `clear_busy` high throughout, `clear_done` one cycle after addr 4095, and `bike_ready` low throughout.
- `clear_req` and bike 0 valid in the same cycle. Expect no accept and the sweep to start.
- `iRST_n` low at sweep addr 0x800. Expect outputs at reset values at once, and no writes after reset releases.
- With `TRAIL_SCHED_DEDUP_EN`: bike 2 sends 0x050 twice. Expect a single write with data 3. A third send of 0x051 produces a write.
